// File: rtl/lutram_readback_checker.sv
// Sweeps every address of a LUTRAM, compares the asynchronous SPO/DPO read bits
// against a selectable expected pattern and records error count and first failure.
module lutram_readback_checker #(
  parameter int A_WIDTH   = 7,
  parameter int ERR_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [1:0]           pattern_i,
  input  logic                 spo_i,
  input  logic                 dpo_i,
  output logic [A_WIDTH-1:0]   addr_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [ERR_WIDTH-1:0] err_cnt_o,
  output logic [A_WIDTH-1:0]   first_err_addr_o,
  output logic [1:0]           first_err_port_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [A_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]           pattern_q, pattern_d;
  logic [ERR_WIDTH-1:0] err_q, err_d;
  logic [A_WIDTH-1:0]   faddr_q, faddr_d;
  logic [1:0]           fport_q, fport_d;
  logic                 seen_q, seen_d;

  logic                 exp_bit;
  logic [1:0]           mism;
  logic [ERR_WIDTH:0]   err_sum;
  logic [ERR_WIDTH-1:0] err_sat;

  // The RAM read is asynchronous, so the bits on spo_i/dpo_i belong to the
  // address presented this very cycle; no pipeline alignment is needed.
  always_comb begin
    exp_bit = 1'b0;
    case (pattern_q)
      2'd0: exp_bit = addr_q[0];
      2'd1: exp_bit = ~addr_q[0];
      2'd2: exp_bit = 1'b0;
      2'd3: exp_bit = 1'b1;
      default: exp_bit = 1'b0;
    endcase
    mism    = {dpo_i != exp_bit, spo_i != exp_bit};
    err_sum = {1'b0, err_q} + (ERR_WIDTH+1)'(mism[0]) + (ERR_WIDTH+1)'(mism[1]);
    // The carry out of the extra MSB can only mean overflow, since at most 2 is added.
    err_sat = err_sum[ERR_WIDTH] ? '1 : err_sum[ERR_WIDTH-1:0];
  end

  // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    pattern_d = pattern_q;
    err_d     = err_q;
    faddr_d   = faddr_q;
    fport_d   = fport_q;
    seen_d    = seen_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d   = CHECK;
          pattern_d = pattern_i;
          addr_d    = '0;
          err_d     = '0;
          faddr_d   = '0;
          fport_d   = '0;
          seen_d    = 1'b0;
        end
      end
      CHECK: begin
        addr_d = addr_q + A_WIDTH'(1);
        err_d  = err_sat;
        if (!seen_q && (mism != 2'b00)) begin
          seen_d  = 1'b1;
          faddr_d = addr_q;
          fport_d = mism;
        end
        if (addr_q == '1) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      pattern_q <= 2'd0;
      err_q     <= '0;
      faddr_q   <= '0;
      fport_q   <= 2'b00;
      seen_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      pattern_q <= pattern_d;
      err_q     <= err_d;
      faddr_q   <= faddr_d;
      fport_q   <= fport_d;
      seen_q    <= seen_d;
    end
  end

  assign addr_o           = addr_q;
  assign busy_o           = (state_q == CHECK);
  assign done_o           = (state_q == DONE);
  assign pass_o           = done_o && (err_q == '0);
  assign err_cnt_o        = err_q;
  assign first_err_addr_o = faddr_q;
  assign first_err_port_o = fport_q;

endmodule

// File: tb/tb_lutram_readback_checker.sv
// Randomized bench for lutram_readback_checker: a modelled async-read RAM feeds the
// checker, and each pass is compared with results computed directly from the RAM contents.
module tb_lutram_readback_checker;

  localparam int AW    = 7;
  localparam int EW    = 8;
  localparam int DEPTH = 1 << AW;
  localparam int EMAX  = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [1:0]    pattern_i;
  logic          spo_i;
  logic          dpo_i;
  logic [AW-1:0] addr_o;
  logic          busy_o;
  logic          done_o;
  logic          pass_o;
  logic [EW-1:0] err_cnt_o;
  logic [AW-1:0] first_err_addr_o;
  logic [1:0]    first_err_port_o;

  logic spo_mem [DEPTH];
  logic dpo_mem [DEPTH];

  int n_vec = 0;
  int n_err = 0;

  int exp_err;
  int exp_faddr;
  int exp_fport;

  always #5 clk = ~clk;

  assign spo_i = spo_mem[addr_o];
  assign dpo_i = dpo_mem[addr_o];

  lutram_readback_checker #(.A_WIDTH(AW), .ERR_WIDTH(EW)) dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start_i),
    .pattern_i        (pattern_i),
    .spo_i            (spo_i),
    .dpo_i            (dpo_i),
    .addr_o           (addr_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .pass_o           (pass_o),
    .err_cnt_o        (err_cnt_o),
    .first_err_addr_o (first_err_addr_o),
    .first_err_port_o (first_err_port_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  function automatic logic exp_bit(input logic [1:0] pat, input int a);
    case (pat)
      2'd0:    return logic'(a % 2);
      2'd1:    return logic'(1 - (a % 2));
      2'd2:    return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Whole-pass result straight from RAM contents: total mismatches clipped at
  // the counter maximum, and the lowest failing address with its port mask.
  task automatic model_pass(input logic [1:0] pat);
    int total;
    total     = 0;
    exp_faddr = -1;
    exp_fport = 0;
    for (int a = 0; a < DEPTH; a++) begin
      int m;
      m = ((spo_mem[a] != exp_bit(pat, a)) ? 1 : 0) + ((dpo_mem[a] != exp_bit(pat, a)) ? 2 : 0);
      total += (m & 1) + (m >> 1);
      if (m != 0 && exp_faddr < 0) begin
        exp_faddr = a;
        exp_fport = m;
      end
    end
    if (exp_faddr < 0) exp_faddr = 0;
    exp_err = (total > EMAX) ? EMAX : total;
  endtask

  task automatic fill(input int mode, input logic [1:0] pat);
    for (int a = 0; a < DEPTH; a++) begin
      case (mode)
        0: begin spo_mem[a] = exp_bit(pat, a); dpo_mem[a] = exp_bit(pat, a); end
        1: begin spo_mem[a] = 1'b1; dpo_mem[a] = 1'b1; end
        default: begin
          // Mostly correct with sparse random flips so first-error capture is exercised.
          spo_mem[a] = exp_bit(pat, a) ^ ($urandom_range(0, 15) == 0);
          dpo_mem[a] = exp_bit(pat, a) ^ ($urandom_range(0, 15) == 0);
        end
      endcase
    end
  endtask

  task automatic run_pass(input string tag, input logic [1:0] pat, input bit mid_start);
    int cnt;
    model_pass(pat);
    @(negedge clk);
    start_i   = 1'b1;
    pattern_i = pat;
    @(negedge clk);
    start_i   = 1'b0;
    pattern_i = 2'($urandom);
    check({tag, "_busy0"}, 32'(busy_o), 32'd1);
    check({tag, "_err0"}, 32'(err_cnt_o), 32'd0);
    cnt = 0;
    while (busy_o === 1'b1 && cnt < 1000) begin
      start_i   = (mid_start && cnt == 10);
      pattern_i = 2'($urandom);
      if (cnt == 64) check({tag, "_pass_mid"}, 32'(pass_o), 32'd0);
      cnt++;
      @(negedge clk);
    end
    start_i = 1'b0;
    check({tag, "_cycles"}, 32'(cnt), 32'(DEPTH));
    check({tag, "_done"}, 32'(done_o), 32'd1);
    check({tag, "_pass"}, 32'(pass_o), 32'(exp_err == 0));
    check({tag, "_errcnt"}, 32'(err_cnt_o), 32'(exp_err));
    check({tag, "_faddr"}, 32'(first_err_addr_o), 32'(exp_faddr));
    check({tag, "_fport"}, 32'(first_err_port_o), 32'(exp_fport));
    check({tag, "_addrwrap"}, 32'(addr_o), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_hold_done"}, 32'(done_o), 32'd1);
    check({tag, "_hold_err"}, 32'(err_cnt_o), 32'(exp_err));
    check({tag, "_hold_faddr"}, 32'(first_err_addr_o), 32'(exp_faddr));
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_addr"}, 32'(addr_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_pass"}, 32'(pass_o), 32'd0);
    check({tag, "_err"}, 32'(err_cnt_o), 32'd0);
    check({tag, "_faddr"}, 32'(first_err_addr_o), 32'd0);
    check({tag, "_fport"}, 32'(first_err_port_o), 32'd0);
  endtask

  initial begin
    int guard;
    logic [1:0] pat;
    rst       = 1'b1;
    start_i   = 1'b1;
    pattern_i = 2'd3;
    fill(0, 2'd0);
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst     = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    check_idle_zero("idle");

    fill(0, 2'd0);
    run_pass("clean_p0", 2'd0, 1'b0);

    spo_mem[5] = ~spo_mem[5];
    run_pass("spo_a5", 2'd0, 1'b0);

    fill(1, 2'd0);
    run_pass("stuck1_p2", 2'd2, 1'b0);

    fill(0, 2'd1);
    dpo_mem[100] = ~dpo_mem[100];
    run_pass("midstart", 2'd1, 1'b1);

    for (int i = 0; i < 6; i++) begin
      pat = 2'($urandom);
      fill(2, pat);
      run_pass($sformatf("rand%0d", i), pat, 1'($urandom));
    end

    fill(2, 2'd3);
    @(negedge clk);
    start_i   = 1'b1;
    pattern_i = 2'd3;
    @(negedge clk);
    start_i = 1'b0;
    guard = 0;
    while (addr_o != AW'(60) && guard < 500) begin
      guard++;
      @(negedge clk);
    end
    check("rst_wait60", 32'(addr_o), 32'd60);
    rst = 1'b1;
    @(negedge clk);
    check_idle_zero("midrst");
    rst = 1'b0;
    @(negedge clk);
    check("midrst_stay_idle", 32'(busy_o), 32'd0);
    fill(2, 2'd3);
    run_pass("after_rst", 2'd3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
